// File: rtl/exec_unit_pkg.sv
// exec_unit_pkg: opcode/funct3 encodings and FSM state type shared by exec_unit and exec_alu
package exec_unit_pkg;
    localparam logic [6:0] OP_NOP    = 7'h00;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_MISC   = 7'h0F;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {S_IDLE, S_EXEC} state_e;
endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational RV32I ALU (a op b by fun3/alt) plus branch comparator (a vs b by fun3)
module exec_alu
    import exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      fun3,
    input  logic            alt,
    output logic [XLEN-1:0] result,
    output logic            branch_taken
);
    logic [4:0]             shamt;
    logic signed [XLEN-1:0] sra;
    logic                   eq, lt, ltu;

    // sra kept in its own signed signal so >>> stays arithmetic inside the unsigned mux below
    assign shamt = b[4:0];
    assign sra   = $signed(a) >>> shamt;
    assign eq    = a == b;
    assign lt    = $signed(a) < $signed(b);
    assign ltu   = a < b;

    always_comb begin
        result = fun3 == F3_ADD  ? (alt ? a - b : a + b) :
                 fun3 == F3_SLL  ? a << shamt :
                 fun3 == F3_SLT  ? {{(XLEN-1){1'b0}}, lt} :
                 fun3 == F3_SLTU ? {{(XLEN-1){1'b0}}, ltu} :
                 fun3 == F3_XOR  ? a ^ b :
                 fun3 == F3_SR   ? (alt ? sra : a >> shamt) :
                 fun3 == F3_OR   ? a | b : a & b;
        branch_taken = fun3 == F3_BEQ  ? eq :
                       fun3 == F3_BNE  ? !eq :
                       fun3 == F3_BLT  ? lt :
                       fun3 == F3_BGE  ? !lt :
                       fun3 == F3_BLTU ? ltu :
                       fun3 == F3_BGEU ? !ltu : 1'b0;
    end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue execute/writeback stage with 32x32 register file; IDLE captures, EXEC retires
module exec_unit
    import exec_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    input  logic [2:0]      fun3,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [6:0]      fun7,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] npc,
    output logic            get_npc,
    output logic            is_busy,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            unsup,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    state_e          state_q;
    logic [XLEN-1:0] rf_q [32];
    logic [6:0]      op_q;
    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic            alt_q;
    logic [XLEN-1:0] imm_q, pc_q, rs1v_q, rs2v_q;
    logic [XLEN-1:0] npc_q, wb_data_q;
    logic [4:0]      wb_rd_q;
    logic            get_npc_q, wb_en_q, unsup_q;
    logic            known, dropped, ctrl_d, wr_d, taken;
    logic [XLEN-1:0] alu_a, alu_b, alu_res, link, npc_d, wb_d;
    logic [2:0]      alu_f3;
    logic            unused;

    assign unused = ^{fun7[6], fun7[4:0]};

    assign known   = opcode == OP_OP || opcode == OP_IMM || opcode == OP_LUI || opcode == OP_AUIPC ||
                     opcode == OP_JAL || opcode == OP_JALR || opcode == OP_BRANCH;
    assign dropped = opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_MISC || opcode == OP_SYSTEM;

    // LUI is 0+imm, AUIPC is pc+imm, JAL/JALR force an add so JALR gets rs1+imm
    assign alu_a  = op_q == OP_LUI ? '0 : op_q == OP_AUIPC ? pc_q : rs1v_q;
    assign alu_b  = (op_q == OP_OP || op_q == OP_BRANCH) ? rs2v_q : imm_q;
    assign alu_f3 = (op_q == OP_OP || op_q == OP_IMM || op_q == OP_BRANCH) ? f3_q : F3_ADD;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .a(alu_a), .b(alu_b), .fun3(alu_f3), .alt(alt_q), .result(alu_res), .branch_taken(taken)
    );

    assign link   = pc_q + XLEN'(4);
    assign ctrl_d = op_q == OP_JAL || op_q == OP_JALR || op_q == OP_BRANCH;
    assign wr_d   = op_q != OP_BRANCH && rd_q != 5'd0;
    assign wb_d   = (op_q == OP_JAL || op_q == OP_JALR) ? link : alu_res;
    assign npc_d  = op_q == OP_JALR ? alu_res & ~XLEN'(1) :
                    (op_q == OP_JAL || (op_q == OP_BRANCH && taken)) ? pc_q + imm_q : link;

    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_EXEC && wr_d) rf_q[rd_q] <= wb_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            npc_q     <= RESET_PC;
            get_npc_q <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            unsup_q   <= 1'b0;
        end else begin
            get_npc_q <= 1'b0;
            wb_en_q   <= 1'b0;
            unsup_q   <= 1'b0;
            if (state_q == S_IDLE) begin
                if (known) begin
                    state_q <= S_EXEC;
                    op_q    <= opcode;
                    rd_q    <= rd;
                    f3_q    <= fun3;
                    // fun7[5] only selects SUB/SRA for OP and SRAI for OP-IMM
                    alt_q   <= fun7[5] && (opcode == OP_OP || (opcode == OP_IMM && fun3 == F3_SR));
                    imm_q   <= imm;
                    pc_q    <= pc;
                    rs1v_q  <= rs1 == 5'd0 ? '0 : rf_q[rs1];
                    rs2v_q  <= rs2 == 5'd0 ? '0 : rf_q[rs2];
                end else begin
                    unsup_q <= dropped;
                end
            end else begin
                state_q   <= S_IDLE;
                npc_q     <= npc_d;
                get_npc_q <= ctrl_d;
                wb_en_q   <= wr_d;
                if (wr_d) begin
                    wb_rd_q   <= rd_q;
                    wb_data_q <= wb_d;
                end
            end
        end
    end

    assign npc      = npc_q;
    assign get_npc  = get_npc_q;
    assign is_busy  = state_q == S_EXEC;
    assign wb_en    = wb_en_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign unsup    = unsup_q;
    assign dbg_data = dbg_addr == 5'd0 ? '0 : rf_q[dbg_addr];
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: scoreboard bench for exec_unit; expected retire records queued at issue, compared on retire
module tb_exec_unit;
    localparam logic [6:0] OP_NOP = 7'h00, OP_LOAD = 7'h03, OP_IMM = 7'h13, OP_AUIPC = 7'h17,
                           OP_OP = 7'h33, OP_LUI = 7'h37, OP_BRANCH = 7'h63, OP_JALR = 7'h67,
                           OP_JAL = 7'h6F;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [6:0]  opcode = '0, fun7 = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0, wb_rd, dbg_addr = '0;
    logic [2:0]  fun3 = '0;
    logic [31:0] imm = '0, pc = '0, npc, wb_data, dbg_data;
    logic        get_npc, is_busy, wb_en, unsup;

    int vectors = 0, miscompares = 0;

    typedef struct packed {
        logic        busy;
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] npc;
        logic        get;
        logic        after;
    } ret_t;

    ret_t  exp_q[$], got_q[$];
    string nm_q[$];

    exec_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .rd(rd), .fun3(fun3), .rs1(rs1), .rs2(rs2),
        .fun7(fun7), .imm(imm), .pc(pc), .npc(npc), .get_npc(get_npc), .is_busy(is_busy),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .unsup(unsup),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic ret_t mk(input logic en, input logic [4:0] r, input logic [31:0] d,
                                input logic [31:0] n, input logic g);
        mk = '{busy: 1'b1, wb_en: en, rd: r, data: d, npc: n, get: g, after: 1'b0};
    endfunction

    // Drives one instruction, records busy in EXEC, the retire outputs, and whether any pulse lingers
    task automatic issue(input string nm, input logic [6:0] op, input logic [4:0] rd_v, rs1_v, rs2_v,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm_v, pc_v,
                         input ret_t e, input logic [6:0] op_exec = OP_NOP);
        ret_t g;
        nm_q.push_back(nm);
        exp_q.push_back(e);
        @(negedge clk);
        opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; fun3 = f3; fun7 = f7; imm = imm_v; pc = pc_v;
        @(posedge clk); #1;
        g.busy = is_busy;
        opcode = op_exec;
        @(posedge clk); #1;
        opcode = OP_NOP;
        g.wb_en = wb_en; g.rd = wb_rd; g.data = wb_data; g.npc = npc; g.get = get_npc;
        @(posedge clk); #1;
        g.after = get_npc | wb_en | is_busy;
        got_q.push_back(g);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({npc, get_npc, is_busy, wb_en, wb_rd, wb_data, unsup} !== {32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: npc=%h get=%b busy=%b wb_en=%b rd=%0d data=%h unsup=%b, want all zero",
                     npc, get_npc, is_busy, wb_en, wb_rd, wb_data, unsup);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_addi;
        ret_t e, g;
        string nm;
        issue("addi_x1", OP_IMM, 1, 0, 0, 3'b000, 7'h00, 32'd5, 32'h10, mk(1, 1, 32'd5, 32'h14, 0));
        issue("addi_wrap", OP_IMM, 15, 1, 0, 3'b000, 7'h00, 32'hFFFF_FFFB, 32'h14, mk(1, 15, 32'd0, 32'h18, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            vectors++;
            if (g.busy !== e.busy || g.wb_en !== e.wb_en || g.npc !== e.npc || g.get !== e.get ||
                g.after !== e.after || (e.wb_en && (g.rd !== e.rd || g.data !== e.data))) begin
                miscompares++;
                $display("FAIL %s: got busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b, want busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b",
                         nm, g.busy, g.wb_en, g.rd, g.data, g.npc, g.get, g.after,
                         e.busy, e.wb_en, e.rd, e.data, e.npc, e.get, e.after);
            end
        end
        dbg_addr = 5'd1; #1;
        vectors++;
        if (dbg_data !== 32'd5) begin
            miscompares++;
            $display("FAIL dbg_x1: got %h want %h", dbg_data, 32'd5);
        end
    endtask

    task automatic test_branch;
        ret_t e, g;
        string nm;
        issue("set_x1", OP_IMM, 1, 0, 0, 3'b000, 7'h00, 32'd7, 32'h18, mk(1, 1, 32'd7, 32'h1C, 0));
        issue("set_x2", OP_IMM, 2, 0, 0, 3'b000, 7'h00, 32'd7, 32'h1C, mk(1, 2, 32'd7, 32'h20, 0));
        issue("beq_taken", OP_BRANCH, 0, 1, 2, 3'b000, 7'h00, -32'sd8, 32'h20, mk(0, 0, 0, 32'h18, 1));
        issue("bne_not", OP_BRANCH, 0, 1, 2, 3'b001, 7'h00, -32'sd8, 32'h20, mk(0, 0, 0, 32'h24, 1));
        issue("br_illegal", OP_BRANCH, 0, 1, 2, 3'b010, 7'h00, -32'sd8, 32'h20, mk(0, 0, 0, 32'h24, 1));
        issue("set_x3", OP_LUI, 3, 0, 0, 3'b000, 7'h00, 32'h8000_0000, 32'h24, mk(1, 3, 32'h8000_0000, 32'h28, 0));
        issue("blt_signed", OP_BRANCH, 0, 3, 1, 3'b100, 7'h00, 32'h40, 32'h28, mk(0, 0, 0, 32'h68, 1));
        issue("bltu_not", OP_BRANCH, 0, 3, 1, 3'b110, 7'h00, 32'h40, 32'h28, mk(0, 0, 0, 32'h2C, 1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            vectors++;
            if (g.busy !== e.busy || g.wb_en !== e.wb_en || g.npc !== e.npc || g.get !== e.get ||
                g.after !== e.after || (e.wb_en && (g.rd !== e.rd || g.data !== e.data))) begin
                miscompares++;
                $display("FAIL %s: got busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b, want busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b",
                         nm, g.busy, g.wb_en, g.rd, g.data, g.npc, g.get, g.after,
                         e.busy, e.wb_en, e.rd, e.data, e.npc, e.get, e.after);
            end
        end
    endtask

    task automatic test_alu;
        ret_t e, g;
        string nm;
        issue("srai", OP_IMM, 4, 3, 0, 3'b101, 7'h20, 32'h0000_0404, 32'h30, mk(1, 4, 32'hF800_0000, 32'h34, 0));
        issue("srli", OP_IMM, 4, 3, 0, 3'b101, 7'h00, 32'h0000_0004, 32'h34, mk(1, 4, 32'h0800_0000, 32'h38, 0));
        issue("sub", OP_OP, 5, 0, 3, 3'b000, 7'h20, 32'h0, 32'h38, mk(1, 5, 32'h8000_0000, 32'h3C, 0));
        issue("sltu", OP_OP, 6, 0, 3, 3'b011, 7'h00, 32'h0, 32'h3C, mk(1, 6, 32'd1, 32'h40, 0));
        issue("slt", OP_OP, 7, 3, 0, 3'b010, 7'h00, 32'h0, 32'h40, mk(1, 7, 32'd1, 32'h44, 0));
        issue("add_wrap", OP_OP, 9, 3, 3, 3'b000, 7'h00, 32'h0, 32'h44, mk(1, 9, 32'h0, 32'h48, 0));
        issue("sra_reg", OP_OP, 10, 3, 1, 3'b101, 7'h20, 32'h0, 32'h48, mk(1, 10, 32'hFF00_0000, 32'h4C, 0));
        issue("auipc", OP_AUIPC, 11, 0, 0, 3'b000, 7'h00, 32'h0000_1000, 32'h100, mk(1, 11, 32'h1100, 32'h104, 0));
        issue("xori", OP_IMM, 12, 3, 0, 3'b100, 7'h00, 32'hFFFF_FFFF, 32'h104, mk(1, 12, 32'h7FFF_FFFF, 32'h108, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            vectors++;
            if (g.busy !== e.busy || g.wb_en !== e.wb_en || g.npc !== e.npc || g.get !== e.get ||
                g.after !== e.after || (e.wb_en && (g.rd !== e.rd || g.data !== e.data))) begin
                miscompares++;
                $display("FAIL %s: got busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b, want busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b",
                         nm, g.busy, g.wb_en, g.rd, g.data, g.npc, g.get, g.after,
                         e.busy, e.wb_en, e.rd, e.data, e.npc, e.get, e.after);
            end
        end
    endtask

    task automatic test_jump;
        ret_t e, g;
        string nm;
        issue("set_x1_103", OP_IMM, 1, 0, 0, 3'b000, 7'h00, 32'h103, 32'h3C, mk(1, 1, 32'h103, 32'h40, 0));
        issue("jalr", OP_JALR, 2, 1, 0, 3'b000, 7'h00, 32'h0, 32'h40, mk(1, 2, 32'h44, 32'h102, 1));
        issue("jal", OP_JAL, 13, 0, 0, 3'b000, 7'h00, 32'h100, 32'h44, mk(1, 13, 32'h48, 32'h144, 1));
        issue("addi_x0", OP_IMM, 0, 0, 0, 3'b000, 7'h00, 32'd9, 32'h50, mk(0, 0, 0, 32'h54, 0));
        issue("jal_x0", OP_JAL, 0, 0, 0, 3'b000, 7'h00, -32'sd16, 32'h54, mk(0, 0, 0, 32'h44, 1));
        issue("raw_inc", OP_IMM, 2, 2, 0, 3'b000, 7'h00, 32'd1, 32'h60, mk(1, 2, 32'h45, 32'h64, 0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
            vectors++;
            if (g.busy !== e.busy || g.wb_en !== e.wb_en || g.npc !== e.npc || g.get !== e.get ||
                g.after !== e.after || (e.wb_en && (g.rd !== e.rd || g.data !== e.data))) begin
                miscompares++;
                $display("FAIL %s: got busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b, want busy=%b en=%b rd=%0d data=%h npc=%h get=%b after=%b",
                         nm, g.busy, g.wb_en, g.rd, g.data, g.npc, g.get, g.after,
                         e.busy, e.wb_en, e.rd, e.data, e.npc, e.get, e.after);
            end
        end
        dbg_addr = 5'd0; #1;
        vectors++;
        if (dbg_data !== 32'h0) begin
            miscompares++;
            $display("FAIL dbg_x0: got %h want 0", dbg_data);
        end
    endtask

    task automatic test_reset_exec;
        ret_t e, g;
        string nm;
        issue("set_x8", OP_IMM, 8, 0, 0, 3'b000, 7'h00, 32'h55, 32'h70, mk(1, 8, 32'h55, 32'h74, 0));
        e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s: got en=%b rd=%0d data=%h npc=%h, want en=%b rd=%0d data=%h npc=%h",
                     nm, g.wb_en, g.rd, g.data, g.npc, e.wb_en, e.rd, e.data, e.npc);
        end
        @(negedge clk);
        opcode = OP_IMM; rd = 5'd8; rs1 = 5'd0; fun3 = 3'b000; fun7 = 7'h00; imm = 32'd1; pc = 32'h80;
        @(posedge clk); #1;
        rst_n = 1'b0; opcode = OP_NOP;
        @(posedge clk); #1;
        dbg_addr = 5'd8; #1;
        vectors++;
        if ({is_busy, wb_en, get_npc, npc, dbg_data} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h55}) begin
            miscompares++;
            $display("FAIL reset_in_exec: got busy=%b en=%b get=%b npc=%h x8=%h, want 0 0 0 00000000 00000055",
                     is_busy, wb_en, get_npc, npc, dbg_data);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({is_busy, wb_en, dbg_data} !== {1'b0, 1'b0, 32'h55}) begin
            miscompares++;
            $display("FAIL reset_release: got busy=%b en=%b x8=%h, want 0 0 00000055", is_busy, wb_en, dbg_data);
        end
    endtask

    task automatic test_ignore_unsup;
        ret_t e, g;
        string nm;
        issue("lui_in_exec", OP_IMM, 11, 0, 0, 3'b000, 7'h00, 32'd3, 32'h90, mk(1, 11, 32'd3, 32'h94, 0), OP_LUI);
        e = exp_q.pop_front(); g = got_q.pop_front(); nm = nm_q.pop_front();
        vectors++;
        if (g !== e) begin
            miscompares++;
            $display("FAIL %s: got busy=%b en=%b rd=%0d data=%h npc=%h after=%b, want busy=%b en=%b rd=%0d data=%h npc=%h after=%b",
                     nm, g.busy, g.wb_en, g.rd, g.data, g.npc, g.after, e.busy, e.wb_en, e.rd, e.data, e.npc, e.after);
        end
        @(negedge clk);
        opcode = OP_LOAD; rd = 5'd11; imm = 32'h77; pc = 32'hA0;
        @(posedge clk); #1;
        opcode = OP_NOP;
        vectors++;
        if ({unsup, is_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL unsup_pulse: got unsup=%b busy=%b, want 1 0", unsup, is_busy);
        end
        @(posedge clk); #1;
        dbg_addr = 5'd11; #1;
        vectors++;
        if ({unsup, wb_en, get_npc, npc, dbg_data} !== {1'b0, 1'b0, 1'b0, 32'h94, 32'd3}) begin
            miscompares++;
            $display("FAIL unsup_after: got unsup=%b en=%b get=%b npc=%h x11=%h, want 0 0 0 00000094 00000003",
                     unsup, wb_en, get_npc, npc, dbg_data);
        end
        @(negedge clk) opcode = OP_NOP;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({is_busy, unsup, wb_en} !== 3'b000) begin
                miscompares++;
                $display("FAIL nop_idle_%0d: got busy=%b unsup=%b en=%b, want 0 0 0", i, is_busy, unsup, wb_en);
            end
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_branch;
        test_alu;
        test_jump;
        test_reset_exec;
        test_ignore_unsup;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
